// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: aligns to `sync`, gathers CHANNELS beats per frame and publishes them atomically.
// Optional parity checking is compiled in with the TDM_PARITY_EN macro.
module tdm_demux #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned W        = 4,
  localparam int unsigned SW      = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [W-1:0]          din,
  input  logic                  din_valid,
  input  logic                  sync,
`ifdef TDM_PARITY_EN
  input  logic                  din_par,
  output logic                  par_err,
`endif
  output logic [CHANNELS*W-1:0] ch_data,
  output logic                  frame_valid,
  output logic                  locked,
  output logic [SW-1:0]         slot,
  output logic                  sync_err,
  output logic [7:0]            frame_cnt
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [SW-1:0] LAST   = SW'(CHANNELS - 1);

  logic [0:0]                   state, state_n;
  logic [SW-1:0]                slot_n;
  logic [CHANNELS-1:0][W-1:0]   shadow, shadow_n, pub;
  logic [CHANNELS*W-1:0]        ch_data_n;
  logic [7:0]                   frame_cnt_n;
  logic                         frame_valid_n, sync_err_n;

`ifdef TDM_PARITY_EN
  logic bad, bad_n, par_err_n, beat_bad;
  assign beat_bad = din_par ^ (^din);
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_HUNT;
      locked      <= 1'b0;
      slot        <= '0;
      shadow      <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= '0;
`ifdef TDM_PARITY_EN
      bad         <= 1'b0;
      par_err     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      locked      <= (state_n == ST_LOCKED);
      slot        <= slot_n;
      shadow      <= shadow_n;
      ch_data     <= ch_data_n;
      frame_valid <= frame_valid_n;
      sync_err    <= sync_err_n;
      frame_cnt   <= frame_cnt_n;
`ifdef TDM_PARITY_EN
      bad         <= bad_n;
      par_err     <= par_err_n;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n       = state;
    slot_n        = slot;
    shadow_n      = shadow;
    ch_data_n     = ch_data;
    frame_cnt_n   = frame_cnt;
    frame_valid_n = 1'b0;
    sync_err_n    = 1'b0;
    pub           = shadow;
    pub[CHANNELS-1] = din;
`ifdef TDM_PARITY_EN
    bad_n         = bad;
    par_err_n     = 1'b0;
`endif
    if (din_valid) begin
      if (state == ST_HUNT) begin
        if (sync) begin
          shadow_n[0] = din;
          slot_n      = SW'(1);
          state_n     = ST_LOCKED;
`ifdef TDM_PARITY_EN
          bad_n       = beat_bad;
`endif
        end
      end else if (sync) begin
        // Early sync restarts the frame; the partial frame is simply overwritten
        sync_err_n  = (slot != '0);
        shadow_n[0] = din;
        slot_n      = SW'(1);
`ifdef TDM_PARITY_EN
        bad_n       = beat_bad;
`endif
      end else if (slot == '0) begin
        sync_err_n = 1'b1;
        state_n    = ST_HUNT;
        slot_n     = '0;
      end else if (slot == LAST) begin
        slot_n = '0;
`ifdef TDM_PARITY_EN
        bad_n  = 1'b0;
        if (bad || beat_bad) begin
          par_err_n = 1'b1;
        end else begin
          ch_data_n     = pub;
          frame_valid_n = 1'b1;
          frame_cnt_n   = frame_cnt + 8'd1;
        end
`else
        ch_data_n     = pub;
        frame_valid_n = 1'b1;
        frame_cnt_n   = frame_cnt + 8'd1;
`endif
      end else begin
        shadow_n[slot] = din;
        slot_n         = slot + SW'(1);
`ifdef TDM_PARITY_EN
        bad_n          = bad | beat_bad;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (CHANNELS=4 main instance, CHANNELS=2 boundary instance).
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  din;
  logic        din_valid;
  logic        sync;
  logic        din_par;
  logic [15:0] ch_data;
  logic        frame_valid, locked, sync_err;
  logic [1:0]  slot;
  logic [7:0]  frame_cnt;
  logic        par_err;
  logic [7:0]  ch_data2;
  logic        frame_valid2, locked2, sync_err2, par_err2;
  logic [0:0]  slot2;
  logic [7:0]  frame_cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tdm_demux #(.CHANNELS(4), .W(4)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .sync(sync),
`ifdef TDM_PARITY_EN
    .din_par(din_par), .par_err(par_err),
`endif
    .ch_data(ch_data), .frame_valid(frame_valid), .locked(locked), .slot(slot),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  tdm_demux #(.CHANNELS(2), .W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .sync(sync),
`ifdef TDM_PARITY_EN
    .din_par(din_par), .par_err(par_err2),
`endif
    .ch_data(ch_data2), .frame_valid(frame_valid2), .locked(locked2), .slot(slot2),
    .sync_err(sync_err2), .frame_cnt(frame_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one beat at the falling edge; on return, outputs still reflect earlier beats
  task automatic beat(input logic s, input logic [3:0] d);
    @(negedge clk);
    din_valid = 1'b1; sync = s; din = d; din_par = ^d;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0; sync = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0; din_par = 1'b0;
    idle(); idle();
    check("rst_ch_data", 32'(ch_data), 32'h0);
    check("rst_locked",  32'(locked), 32'h0);
    check("rst_cnt",     32'(frame_cnt), 32'h0);
    reset_n = 1'b1;

    // Basic frame
    beat(1'b1, 4'hA); beat(1'b0, 4'h5);
    check("slot_after_b0", 32'(slot), 32'h1);
    beat(1'b0, 4'h3);
    check("c2_ch_data", 32'(ch_data2), 32'h5A);
    check("c2_fvalid",  32'(frame_valid2), 32'h1);
    beat(1'b0, 4'hC);
    check("pre_pub_fvalid", 32'(frame_valid), 32'h0);
    idle();
    check("f1_ch_data", 32'(ch_data), 32'hC35A);
    check("f1_fvalid",  32'(frame_valid), 32'h1);
    check("f1_cnt",     32'(frame_cnt), 32'h1);
    check("f1_locked",  32'(locked), 32'h1);
    check("f1_slot",    32'(slot), 32'h0);
    idle();
    check("f1_fvalid_drop", 32'(frame_valid), 32'h0);

    // Same frame with idle gaps
    beat(1'b1, 4'hA); idle(); beat(1'b0, 4'h5); idle(); idle();
    beat(1'b0, 4'h3); idle(); idle(); idle();
    check("gap_no_fvalid", 32'(frame_valid), 32'h0);
    check("gap_slot",      32'(slot), 32'h3);
    beat(1'b0, 4'hC); idle();
    check("gap_ch_data", 32'(ch_data), 32'hC35A);
    check("gap_fvalid",  32'(frame_valid), 32'h1);
    check("gap_cnt",     32'(frame_cnt), 32'h2);

    // Early sync
    beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b1, 4'h7); beat(1'b0, 4'h8);
    check("early_sync_err", 32'(sync_err), 32'h1);
    check("early_slot",     32'(slot), 32'h1);
    check("early_hold",     32'(ch_data), 32'hC35A);
    beat(1'b0, 4'h9);
    check("early_err_drop", 32'(sync_err), 32'h0);
    beat(1'b0, 4'hA); idle();
    check("early_ch_data", 32'(ch_data), 32'hA987);
    check("early_cnt",     32'(frame_cnt), 32'h3);
    check("early_no_err",  32'(sync_err), 32'h0);

    // Missing sync at frame start, then relock
    beat(1'b0, 4'h5); idle();
    check("miss_sync_err", 32'(sync_err), 32'h1);
    check("miss_locked",   32'(locked), 32'h0);
    beat(1'b0, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h3); beat(1'b0, 4'h4); idle();
    check("hunt_locked", 32'(locked), 32'h0);
    check("hunt_slot",   32'(slot), 32'h0);
    beat(1'b1, 4'hD); beat(1'b0, 4'hE); beat(1'b0, 4'hF); beat(1'b0, 4'h0); idle();
    check("relock_ch_data", 32'(ch_data), 32'h0FED);
    check("relock_cnt",     32'(frame_cnt), 32'h4);

    // Asynchronous reset mid-frame
    beat(1'b1, 4'h1); beat(1'b0, 4'h2);
    @(negedge clk);
    din_valid = 1'b0; reset_n = 1'b0;
    #1;
    check("arst_ch_data", 32'(ch_data), 32'h0);
    check("arst_cnt",     32'(frame_cnt), 32'h0);
    check("arst_locked",  32'(locked), 32'h0);
    check("arst_slot",    32'(slot), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    beat(1'b0, 4'h9); beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h3); beat(1'b0, 4'h4); idle();
    check("post_rst_ch_data", 32'(ch_data), 32'h4321);
    check("post_rst_cnt",     32'(frame_cnt), 32'h1);

    // Frame counter wrap: 254 more frames reach 255, one more wraps to 0
    for (int i = 0; i < 254; i++) begin
      beat(1'b1, 4'(i)); beat(1'b0, 4'(i + 1)); beat(1'b0, 4'(i + 2)); beat(1'b0, 4'(i + 3));
    end
    idle();
    check("cnt_255", 32'(frame_cnt), 32'hFF);
    beat(1'b1, 4'hE); beat(1'b0, 4'hF); beat(1'b0, 4'h0); beat(1'b0, 4'h1); idle();
    check("cnt_wrap",      32'(frame_cnt), 32'h0);
    check("wrap_ch_data",  32'(ch_data), 32'h10FE);

`ifdef TDM_PARITY_EN
    // Bad parity on slot 2 suppresses the publish
    beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h3);
    din_par = ~din_par;
    beat(1'b0, 4'h4); idle();
    check("par_err",      32'(par_err), 32'h1);
    check("par_ch_data",  32'(ch_data), 32'h10FE);
    check("par_cnt",      32'(frame_cnt), 32'h0);
    check("par_no_fv",    32'(frame_valid), 32'h0);
    check("par_locked",   32'(locked), 32'h1);
    idle();
    check("par_err_drop", 32'(par_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
